// File: rtl/xorg_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// xorg_ctrl_pkg
// Shared definitions for the bit-serial XOR arbiter: FSM state codes and
// the sizing rule for the bit counter.
// No ports (package).
// -----------------------------------------------------------------------------
package xorg_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // The counter must be able to hold the value WIDTH itself, because it
  // increments once more on the final shift.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/xorg.sv
// -----------------------------------------------------------------------------
// xorg
// Gate-level single-bit XOR primitive shared by the serial arbiter.
// Ports:
//   a_i, b_i : input bits
//   y_o      : a_i XOR b_i
// -----------------------------------------------------------------------------
module xorg (
  input  logic a_i,
  input  logic b_i,
  output logic y_o
);

  xor u_xor (y_o, a_i, b_i);

endmodule

// File: rtl/xorg_serial_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin selector. Searches req_i upward starting one
// above last_winner_i, wrapping at N_REQ, and returns the first set bit.
// Ports:
//   req_i         : request vector, bit i = requester i
//   last_winner_i : index of the most recently served requester
//   winner_o      : selected requester index (0 when valid_o is low)
//   valid_o       : high when any request bit is set
// -----------------------------------------------------------------------------
module rr_pick #(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]         req_i,
  input  logic [$clog2(N_REQ)-1:0] last_winner_i,
  output logic [$clog2(N_REQ)-1:0] winner_o,
  output logic                     valid_o
);

  localparam int IDX_W = $clog2(N_REQ);

  // NOTE: every output of a combinational block gets a default before any
  // conditional assignment; otherwise a path that skips it infers a latch.
  always_comb begin
    winner_o = '0;
    valid_o  = 1'b0;
    // off runs 1..N_REQ so the last candidate is last_winner itself.
    for (int off = 1; off <= N_REQ; off++) begin
      int idx;
      idx = (int'(last_winner_i) + off) % N_REQ;
      if (!valid_o && req_i[idx]) begin
        valid_o  = 1'b1;
        winner_o = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/xorg_serial_arbiter.sv
// -----------------------------------------------------------------------------
// xorg_serial_arbiter
// Shares one gate-level XOR between N_REQ requesters. A round-robin winner
// is granted, its operands are captured and fed LSB first through the single
// xorg instance, and the WIDTH-bit result is returned with a done pulse.
// Ports:
//   clk     : clock, rising edge
//   rst     : synchronous active-high reset
//   req     : level requests, bit i = requester i
//   a_in    : operand A, requester i uses [i*WIDTH +: WIDTH]
//   b_in    : operand B, same slicing
//   gnt     : registered one-hot grant, high during the LOAD cycle
//   busy    : high whenever the FSM is not idle
//   result  : registered XOR result, held until the next completion
//   done    : one-cycle pulse, result valid in this cycle
//   done_id : requester index that owns result
// -----------------------------------------------------------------------------
module xorg_serial_arbiter
  import xorg_ctrl_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ*WIDTH-1:0]   a_in,
  input  logic [N_REQ*WIDTH-1:0]   b_in,
  output logic [N_REQ-1:0]         gnt,
  output logic                     busy,
  output logic [WIDTH-1:0]         result,
  output logic                     done,
  output logic [$clog2(N_REQ)-1:0] done_id
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int CNT_W = cnt_width(WIDTH);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   winner_q, winner_d;
  logic [IDX_W-1:0]   last_winner_q, last_winner_d;
  logic [IDX_W-1:0]   done_id_q, done_id_d;
  logic [WIDTH-1:0]   a_sr_q, a_sr_d;
  logic [WIDTH-1:0]   b_sr_q, b_sr_d;
  logic [WIDTH-1:0]   res_sr_q, res_sr_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [N_REQ-1:0]   gnt_q, gnt_d;
  logic               done_q, done_d;

  logic [IDX_W-1:0]   pick_winner;
  logic               pick_valid;
  logic               xor_bit;

  rr_pick #(.N_REQ(N_REQ)) u_rr_pick (
    .req_i         (req),
    .last_winner_i (last_winner_q),
    .winner_o      (pick_winner),
    .valid_o       (pick_valid)
  );

  // The only XOR in the datapath: one bit per SHIFT cycle.
  xorg u_xorg (
    .a_i (a_sr_q[0]),
    .b_i (b_sr_q[0]),
    .y_o (xor_bit)
  );

  always_comb begin
    state_d       = state_q;
    winner_d      = winner_q;
    last_winner_d = last_winner_q;
    done_id_d     = done_id_q;
    a_sr_d        = a_sr_q;
    b_sr_d        = b_sr_q;
    res_sr_d      = res_sr_q;
    result_d      = result_q;
    cnt_d         = cnt_q;
    gnt_d         = '0;
    done_d        = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          winner_d           = pick_winner;
          gnt_d[pick_winner] = 1'b1;
          state_d            = ST_LOAD;
        end
      end
      ST_LOAD: begin
        // Operands only need to be stable in this cycle.
        a_sr_d  = a_in[int'(winner_q)*WIDTH +: WIDTH];
        b_sr_d  = b_in[int'(winner_q)*WIDTH +: WIDTH];
        cnt_d   = '0;
        state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        a_sr_d   = a_sr_q >> 1;
        b_sr_d   = b_sr_q >> 1;
        res_sr_d = {xor_bit, res_sr_q[WIDTH-1:1]};
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          // Publish on the edge into DONE so result is valid with done.
          result_d      = res_sr_d;
          done_d        = 1'b1;
          done_id_d     = winner_q;
          last_winner_d = winner_q;
          state_d       = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      winner_q      <= '0;
      last_winner_q <= IDX_W'(N_REQ - 1);
      done_id_q     <= '0;
      a_sr_q        <= '0;
      b_sr_q        <= '0;
      res_sr_q      <= '0;
      result_q      <= '0;
      cnt_q         <= '0;
      gnt_q         <= '0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      winner_q      <= winner_d;
      last_winner_q <= last_winner_d;
      done_id_q     <= done_id_d;
      a_sr_q        <= a_sr_d;
      b_sr_q        <= b_sr_d;
      res_sr_q      <= res_sr_d;
      result_q      <= result_d;
      cnt_q         <= cnt_d;
      gnt_q         <= gnt_d;
      done_q        <= done_d;
    end
  end

  assign gnt     = gnt_q;
  assign busy    = (state_q != ST_IDLE);
  assign result  = result_q;
  assign done    = done_q;
  assign done_id = done_id_q;

endmodule

// File: doc/xorg_serial_arbiter.md
Name: xorg_serial_arbiter

Overview:
Shares one structural xorg gate instance between N_REQ requesters. Each requester presents two WIDTH-bit operands. The block grants the shared XOR resource round-robin and feeds the operands through it bit-serially, LSB first. It returns the WIDTH-bit XOR result with a one-cycle done pulse, and sits between requesting datapath blocks and the gate-level XOR primitive.

Parameters:
N_REQ, 4, number of requesters (>=2)
WIDTH, 8, operand/result width in bits (>=2)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous, active-high reset
req  input  N_REQ  level request per requester; bit i = requester i
a_in  input  N_REQ*WIDTH  operand A; requester i uses slice [i*WIDTH +: WIDTH]
b_in  input  N_REQ*WIDTH  operand B; same slicing as a_in
gnt  output  N_REQ  one-hot grant, registered, high for exactly one cycle
busy  output  1  high whenever the FSM is not in IDLE
result  output  WIDTH  XOR result, registered, held until the next DONE
done  output  1  one-cycle pulse; result is valid in this cycle
done_id  output  $clog2(N_REQ)  index of the requester whose result is on result

Behaviour:
- Clocking and reset: one clock, clk; reset is synchronous and active-high, rst.
- Reset values: state=IDLE, gnt=0, busy=0, done=0, result=0, done_id=0, bit counter=0, shift registers=0, last_winner=N_REQ-1 (so requester 0 has top priority after reset).
- FSM states: IDLE, LOAD, SHIFT, DONE. Encoding is 2-bit, held in the package.
- IDLE, no req: stay in IDLE.
- IDLE, any req bit high: pick the first set bit searching upward from last_winner+1, with wrap-around. Register the winner, set gnt[winner]=1, go to LOAD.
- LOAD: gnt high for this cycle only. At the end of this cycle:
  - capture the winner's a_in/b_in slices into a_sr/b_sr;
  - clear the counter;
  - go to SHIFT.
  Operands must be stable only during the LOAD cycle; later changes have no effect.
- SHIFT: each cycle:
  - a_sr[0] and b_sr[0] drive the single xorg instance;
  - the xorg output shifts into res_sr at the MSB (res_sr shifts right);
  - a_sr and b_sr shift right;
  - the counter increments.
  After the WIDTH-th shift, go to DONE.
- DONE: result<=res_sr, done=1, done_id=winner, last_winner<=winner. Always go to IDLE next; no arbitration in DONE.
- Timing: call the IDLE cycle in which req is sampled C0.
  - gnt is high in C1.
  - SHIFT occupies C2..C(WIDTH+1).
  - done is high in C(WIDTH+2), i.e. C10 at default WIDTH.
  - Back-to-back service period is WIDTH+3 cycles.
- Requests are level-sensitive and are not latched.
  - A req raised while busy is considered at the next IDLE if it is still high.
  - A req dropped before it is sampled in IDLE is lost.
- Once granted, the operation completes even if req drops.
- A req still high in the cycle after its own DONE counts as a new request and takes its round-robin turn.
- Simultaneous requests resolve round-robin only; no fixed priority beyond the reset pointer.
- rst asserted in any state aborts the operation:
  - no done is issued;
  - all outputs return to their reset values on the next edge;
  - the aborted requester must re-request.
- The XOR bit must come from the xorg instance, not a behavioural ^.

Decomposition:
- Shared package/header xorg_ctrl_pkg holds:
  - state codes ST_IDLE=2'd0, ST_LOAD=2'd1, ST_SHIFT=2'd2, ST_DONE=2'd3;
  - the width of the bit counter.
- One combinational sub-module, rr_pick: inputs req and last_winner; outputs winner index and a valid flag.
- The top module holds the FSM, the shift registers and the single xorg instance.

Test Plan:
- Single request after reset: rst for 2 cycles, then req=4'b0001, a=0xA5, b=0x0F → gnt=4'b0001 in C1, busy high C1–C10, done in C10, result=0xAA, done_id=0.
- All four requesters, held until granted, simultaneously: req=4'b1111 from C0; operand pairs (0x01,0x10), (0x22,0x02), (0xF0,0x0F), (0x55,0x55) → grant order 0,1,2,3, with done at C10, C21, C32, C43. Results 0x11, 0x20, 0xFF, 0x00; done_id 0,1,2,3.
- Fairness: req1 and req3 held high continuously for 6 operations → grants alternate 1,3,1,3,1,3; req0 never granted.
- Reset mid-operation: req0 with a=0x3C, b=0xC3; rst high in C5 → from the next cycle busy=0, gnt=0, result=0 and done never pulses for that operation. The re-request then completes with result=0xFF.
- Operand and request stability: change a_in/b_in to random values in C2–C9 and drop req in C2 → result equals the XOR of the values present in C1 (a=0xFF, b=0x00 → 0xFF), with done still pulsed.
- Boundary values: a=b=0xFF → result 0x00. a=0x80, b=0x00 → result 0x80, which confirms the MSB lands in the correct position.
